// File: rtl/inverter_pipe.sv
// Per-lane pass / invert / negate / masked-invert over a valid/ready stream.
// Latency: one cycle from accept to out_* when main is empty or draining.
// Backpressure: 2-entry skid; in_ready is registered (!skid_valid), full rate holds.
module inverter_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [2*CHANNELS-1:0]     in_mode,
  input  logic [WIDTH-1:0]          in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_ovf,
  output logic [CNT_W-1:0]          xfer_count
);

  localparam int DW = CHANNELS * WIDTH;

  // Returns {ovf, result} for one lane. Negating the most-negative value
  // yields the same pattern, which is exactly the case flagged as overflow.
  function automatic logic [WIDTH:0] lane_xform(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] mask
  );
    logic [WIDTH-1:0] min_neg;
    logic [WIDTH:0]   res;
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    case (mode)
      2'b00:   res = {1'b0, x};
      2'b01:   res = {1'b0, ~x};
      2'b10:   res = {(x == min_neg), ~x + WIDTH'(1)};
      default: res = {1'b0, x ^ mask};
    endcase
    return res;
  endfunction

  logic [DW-1:0]       next_data;
  logic [CHANNELS-1:0] next_ovf;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [WIDTH:0] lane_res;
    assign lane_res = lane_xform(in_data[g*WIDTH +: WIDTH], in_mode[2*g +: 2], in_mask);
    assign next_data[g*WIDTH +: WIDTH] = lane_res[WIDTH-1:0];
    assign next_ovf[g]                 = lane_res[WIDTH];
  end

  logic                main_valid;
  logic [DW-1:0]       main_data;
  logic [CHANNELS-1:0] main_ovf;
  logic                skid_valid;
  logic [DW-1:0]       skid_data;
  logic [CHANNELS-1:0] skid_ovf;

  logic accept;
  logic xfer;

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign xfer      = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ovf   = main_ovf;

  // Two-entry storage: main feeds the output, skid catches the beat that
  // arrives while main is stalled. Skid refills main before any new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ovf   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ovf   <= '0;
    end else if (xfer) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_ovf   <= skid_ovf;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= next_data;
        main_ovf   <= next_ovf;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_data  <= next_data;
        main_ovf   <= next_ovf;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= next_data;
        skid_ovf   <= next_ovf;
      end
    end
  end

  // Completed output transfers, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (xfer) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inverter_pipe.sv
// Bench for inverter_pipe: directed mode/overflow/backpressure/reset steps,
// a randomized phase against a 2-deep queue model, and a counter-wrap check
// on a second instance with a 2-bit transfer counter.
module tb_inverter_pipe;

  localparam int W  = 4;
  localparam int C  = 2;
  localparam int DW = W * C;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2*C-1:0] in_mode;
  logic [W-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [C-1:0]  out_ovf;
  logic [7:0]    xfer_count;

  logic          w_valid;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [DW-1:0] w_out_data;
  logic [C-1:0]  w_out_ovf;
  logic [1:0]    w_count;

  always #5 clk = ~clk;

  inverter_pipe #(.WIDTH(W), .CHANNELS(C), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .xfer_count(xfer_count)
  );

  inverter_pipe #(.WIDTH(W), .CHANNELS(C), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(w_valid), .in_ready(w_in_ready), .in_data(8'h00),
    .in_mode(4'b0000), .in_mask(4'b0000),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .xfer_count(w_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [C-1:0]  ovf;
  } beat_t;

  beat_t q[$];
  int    exp_cnt = 0;
  int    checks  = 0;
  int    errors  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference transform from plain integer arithmetic on each lane.
  function automatic beat_t ref_beat(input logic [DW-1:0] d, input logic [2*C-1:0] m,
                                     input logic [W-1:0] mask);
    beat_t b;
    int    full;
    full   = 1 << W;
    b.data = '0;
    b.ovf  = '0;
    for (int i = 0; i < C; i++) begin
      int x;
      int md;
      int r;
      x  = int'(d[i*W +: W]);
      md = int'(m[2*i +: 2]);
      case (md)
        0:       r = x;
        1:       r = (full - 1) - x;
        2:       r = (full - x) % full;
        default: r = x ^ int'(mask);
      endcase
      b.data[i*W +: W] = W'(r);
      b.ovf[i] = (md == 2) && (x == full / 2);
    end
    return b;
  endfunction

  task automatic check_outputs();
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].data);
      check("out_ovf", out_ovf, q[0].ovf);
    end
    check("xfer_count", xfer_count, exp_cnt % 256);
  endtask

  // One clock: predict accept/transfer from the queue occupancy, advance
  // the model at the edge, then compare on the falling edge.
  task automatic tick();
    bit    acc;
    bit    xf;
    beat_t nb;
    acc = in_valid && (q.size() < 2);
    xf  = out_ready && (q.size() > 0);
    nb  = ref_beat(in_data, in_mode, in_mask);
    @(posedge clk);
    if (xf) begin
      void'(q.pop_front());
      exp_cnt++;
    end
    if (acc) q.push_back(nb);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [2*C-1:0] m,
                       input logic [W-1:0] mask, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_mask   = mask;
    out_ready = ordy;
    tick();
  endtask

  initial begin
    int         base;
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = '0; in_mask = '0; out_ready = 1'b0;
    w_valid = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_xfer_count", xfer_count, 0);
    check("rst_wrap_count", w_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Mode sweep
    drive(1'b1, 8'h3E, 4'b0100, 4'b0000, 1'b1);
    check("sweep_inv_pass", out_data, 8'hCE);
    drive(1'b1, 8'h3E, 4'b1011, 4'b1010, 1'b1);
    check("sweep_neg_mask", out_data, 8'hD4);

    // Overflow and negate-of-zero
    drive(1'b1, 8'h18, 4'b0010, 4'b0000, 1'b1);
    check("ovf_data", out_data, 8'h18);
    check("ovf_flag", out_ovf, 2'b01);
    drive(1'b1, 8'h10, 4'b0010, 4'b0000, 1'b1);
    check("neg0_data", out_data, 8'h10);
    check("neg0_flag", out_ovf, 2'b00);
    drive(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Backpressure: A into main, B into skid, C held upstream
    base = exp_cnt;
    drive(1'b1, 8'h5A, 4'b0101, 4'b0000, 1'b0);
    drive(1'b1, 8'hC3, 4'b1010, 4'b0000, 1'b0);
    check("bp_in_ready_low", in_ready, 0);
    drive(1'b1, 8'h81, 4'b1111, 4'b0110, 1'b0);
    check("bp_hold_a", out_data, 8'hA5);
    drive(1'b1, 8'h81, 4'b1111, 4'b0110, 1'b1);
    drive(1'b1, 8'h81, 4'b1111, 4'b0110, 1'b1);
    drive(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    check("bp_count", xfer_count, (base + 3) % 256);
    check("bp_empty", out_valid, 0);

    // Random stress
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), (2*C)'($urandom), W'($urandom),
            1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    check("rand_count", xfer_count, exp_cnt % 256);

    // Reset mid-operation with main and skid full
    drive(1'b1, 8'h12, 4'b0001, 4'b0000, 1'b0);
    drive(1'b1, 8'h34, 4'b0100, 4'b0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_xfer_count", xfer_count, 0);
    check("midrst_out_data", out_data, 0);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h77, 4'b0001, 4'b0000, 1'b1);
    check("postrst_data", out_data, 8'h78);
    drive(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Counter wrap on the 2-bit instance
    for (int i = 0; i < 6; i++) begin
      w_valid = (i < 5);
      @(posedge clk);
      @(negedge clk);
      if (i > 0) check("wrap_count", w_count, seq[i-1]);
    end
    w_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
